// File: rtl/cache_pkg.sv
// Shared defaults, address-field widths and FSM state type for the direct-mapped
// write-through cache controller.
package cache_pkg;

  localparam int unsigned ADDR_W_DEF     = 10;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned NUM_LINES_DEF  = 8;
  localparam int unsigned LINE_WORDS_DEF = 4;

  localparam int unsigned OFF_W_DEF = $clog2(LINE_WORDS_DEF);
  localparam int unsigned IDX_W_DEF = $clog2(NUM_LINES_DEF);
  localparam int unsigned TAG_W_DEF = ADDR_W_DEF - IDX_W_DEF - OFF_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WRITE  = 2'd2
  } cache_state_e;

  function automatic int unsigned tag_width(input int unsigned addr_w,
                                            input int unsigned num_lines,
                                            input int unsigned line_words);
    return addr_w - $clog2(num_lines) - $clog2(line_words);
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Tag, valid and data arrays: one combinational read port, one synchronous write port.
// Only the valid bits are reset; tag/data contents are don't-care while invalid.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned TAG_W  = TAG_W_DEF,
  parameter int unsigned IDX_W  = IDX_W_DEF,
  parameter int unsigned OFF_W  = OFF_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic [OFF_W-1:0]  rd_off_i,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [OFF_W-1:0]  wr_off_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_tag_en_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic              wr_valid_i
);

  localparam int unsigned NUM_LINES  = 1 << IDX_W;
  localparam int unsigned LINE_WORDS = 1 << OFF_W;

  logic [DATA_W-1:0]    data_q [NUM_LINES][LINE_WORDS];
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;

  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i][rd_off_i];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en_i && wr_tag_en_i) begin
      valid_q[wr_idx_i] <= wr_valid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en_i) begin
      data_q[wr_idx_i][wr_off_i] <= wr_data_i;
      if (wr_tag_en_i) begin
        tag_q[wr_idx_i] <= wr_tag_i;
      end
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller (IDLE/REFILL/WRITE).
// Optional hit/miss statistics outputs are enabled by defining CACHE_STATS_EN.
module cache_controller
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned NUM_LINES  = NUM_LINES_DEF,
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = tag_width(ADDR_W, NUM_LINES, LINE_WORDS);

  cache_state_e     state_q, state_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic             wr_done_q, wr_done_d;

  logic [OFF_W-1:0]  cpu_off;
  logic [IDX_W-1:0]  cpu_idx;
  logic [TAG_W-1:0]  cpu_tag;
  logic [TAG_W-1:0]  line_tag;
  logic              line_valid;
  logic [DATA_W-1:0] line_data;
  logic              hit;
  logic              wr_pending;

  logic              st_wr_en;
  logic [OFF_W-1:0]  st_wr_off;
  logic [DATA_W-1:0] st_wr_data;
  logic              st_tag_en;
  logic              st_valid;

  assign cpu_off = cpu_addr[OFF_W-1:0];
  assign cpu_idx = cpu_addr[OFF_W +: IDX_W];
  assign cpu_tag = cpu_addr[ADDR_W-1 -: TAG_W];

  assign hit       = line_valid && (line_tag == cpu_tag);
  assign cpu_rdata = line_data;

  // cpu_wr stays high until the stall drops, so a completed write must not be
  // re-issued while the held request (possibly a combined read) finishes.
  assign wr_pending = cpu_wr && !wr_done_q;

  cache_line_store #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .IDX_W  (IDX_W),
    .OFF_W  (OFF_W)
  ) u_store (
    .clk         (clk),
    .rst         (rst),
    .rd_idx_i    (cpu_idx),
    .rd_off_i    (cpu_off),
    .rd_tag_o    (line_tag),
    .rd_valid_o  (line_valid),
    .rd_data_o   (line_data),
    .wr_en_i     (st_wr_en),
    .wr_idx_i    (cpu_idx),
    .wr_off_i    (st_wr_off),
    .wr_data_i   (st_wr_data),
    .wr_tag_en_i (st_tag_en),
    .wr_tag_i    (cpu_tag),
    .wr_valid_i  (st_valid)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_done_d  = wr_done_q;
    cpu_stall  = 1'b0;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    st_wr_en   = 1'b0;
    st_wr_off  = cpu_off;
    st_wr_data = mem_rdata;
    st_tag_en  = 1'b0;
    st_valid   = 1'b0;

    if (!rst) begin
      unique case (state_q)
        ST_IDLE: begin
          if (wr_pending) begin
            cpu_stall = 1'b1;
            state_d   = ST_WRITE;
          end else if (cpu_rd && !hit) begin
            cpu_stall = 1'b1;
            state_d   = ST_REFILL;
            cnt_d     = '0;
          end
          if (!cpu_stall) begin
            wr_done_d = 1'b0;
          end
        end

        // The line is invalidated by its first refill word and only marked
        // valid by the last, so an aborted refill never leaves a partial line.
        ST_REFILL: begin
          cpu_stall = 1'b1;
          mem_rd_en = 1'b1;
          mem_addr  = {cpu_tag, cpu_idx, cnt_q};
          if (mem_ready) begin
            st_wr_en   = 1'b1;
            st_wr_off  = cnt_q;
            st_wr_data = mem_rdata;
            st_tag_en  = 1'b1;
            st_valid   = &cnt_q;
            cnt_d      = cnt_q + 1'b1;
            if (&cnt_q) begin
              state_d = ST_IDLE;
            end
          end
        end

        ST_WRITE: begin
          cpu_stall = 1'b1;
          mem_wr_en = 1'b1;
          if (hit) begin
            st_wr_en   = 1'b1;
            st_wr_data = cpu_wdata;
          end
          wr_done_d = 1'b1;
          state_d   = ST_IDLE;
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_done_q <= wr_done_d;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_q, hit_d;
  logic [31:0] miss_q, miss_d;
  logic        miss_pend_q, miss_pend_d;
  logic        idle_rd;

  assign idle_rd = !rst && (state_q == ST_IDLE) && !wr_pending && cpu_rd;

  // The hit that completes a refilled request belongs to its earlier miss.
  always_comb begin
    hit_d       = hit_q;
    miss_d      = miss_q;
    miss_pend_d = miss_pend_q;
    if (idle_rd) begin
      if (hit) begin
        if (miss_pend_q) begin
          miss_pend_d = 1'b0;
        end else if (hit_q != '1) begin
          hit_d = hit_q + 32'd1;
        end
      end else begin
        if (miss_q != '1) begin
          miss_d = miss_q + 32'd1;
        end
        miss_pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q       <= '0;
      miss_q      <= '0;
      miss_pend_q <= 1'b0;
    end else begin
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      miss_pend_q <= miss_pend_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: transaction-level cache/memory model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cache_controller;

  localparam int K_STALL  = 0;
  localparam int K_RD     = 1;
  localparam int K_WR     = 2;
  localparam int K_DONE_R = 3;
  localparam int K_DONE_W = 4;

  typedef struct {
    int          kind;
    logic [9:0]  a;
    logic [31:0] d;
  } step_t;

  logic        clk;
  logic        rst;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  cache_controller #(
    .ADDR_W     (10),
    .DATA_W     (32),
    .NUM_LINES  (8),
    .LINE_WORDS (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: backing memory plus which tag each line holds.
  logic [31:0] mem [1024];
  bit          mv  [8];
  logic [4:0]  mt  [8];

  step_t       q[$];
  logic [9:0]  racc[$];
  logic [31:0] last_rdata;
  bit          force_rdy;
  int          total;
  int          bad;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Expected cycle-by-cycle shape of one held request, from the cache policy.
  task automatic build(input bit rd, input bit wr, input logic [9:0] a, input logic [31:0] d);
    logic [2:0] idx;
    logic [4:0] tg;
    bit         h;
    logic [1:0] w;
    idx = a[4:2];
    tg  = a[9:5];
    h   = mv[idx] && (mt[idx] == tg);
    if (wr) begin
      q.push_back('{K_STALL, a, d});
      q.push_back('{K_WR, a, d});
    end
    if (rd) begin
      if (!h) begin
        q.push_back('{K_STALL, a, d});
        for (int k = 0; k < 4; k++) begin
          w = 2'(k);
          q.push_back('{K_RD, {a[9:2], w}, d});
        end
        mv[idx] = 1'b1;
        mt[idx] = tg;
      end
      q.push_back('{K_DONE_R, a, d});
    end else begin
      q.push_back('{K_DONE_W, a, d});
    end
  endtask

  // One clock cycle: drive memory response, check outputs, advance to next edge+1.
  task automatic cycle();
    step_t s;
    mem_ready = force_rdy ? 1'b1 : ($urandom_range(0, 2) != 0);
    #1;
    mem_rdata = mem[mem_addr];
    #1;
    if (rst || q.size() == 0) begin
      chk("quiet_stall", 32'(cpu_stall), 32'd0);
      chk("quiet_rd_en", 32'(mem_rd_en), 32'd0);
      chk("quiet_wr_en", 32'(mem_wr_en), 32'd0);
    end else begin
      s = q[0];
      case (s.kind)
        K_STALL: begin
          chk("idle_stall", 32'(cpu_stall), 32'd1);
          chk("idle_rd_en", 32'(mem_rd_en), 32'd0);
          chk("idle_wr_en", 32'(mem_wr_en), 32'd0);
          void'(q.pop_front());
        end
        K_RD: begin
          chk("refill_stall", 32'(cpu_stall), 32'd1);
          chk("refill_rd_en", 32'(mem_rd_en), 32'd1);
          chk("refill_wr_en", 32'(mem_wr_en), 32'd0);
          chk("refill_addr", 32'(mem_addr), 32'(s.a));
          if (mem_ready) begin
            racc.push_back(mem_addr);
            void'(q.pop_front());
          end
        end
        K_WR: begin
          chk("write_stall", 32'(cpu_stall), 32'd1);
          chk("write_wr_en", 32'(mem_wr_en), 32'd1);
          chk("write_rd_en", 32'(mem_rd_en), 32'd0);
          chk("write_addr", 32'(mem_addr), 32'(s.a));
          chk("write_data", mem_wdata, s.d);
          mem[s.a] = s.d;
          void'(q.pop_front());
        end
        K_DONE_R: begin
          chk("rd_done_stall", 32'(cpu_stall), 32'd0);
          chk("rd_done_rd_en", 32'(mem_rd_en), 32'd0);
          chk("rd_done_data", cpu_rdata, mem[s.a]);
          last_rdata = cpu_rdata;
          void'(q.pop_front());
        end
        default: begin
          chk("wr_done_stall", 32'(cpu_stall), 32'd0);
          chk("wr_done_wr_en", 32'(mem_wr_en), 32'd0);
          void'(q.pop_front());
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_req(input bit rd, input bit wr, input logic [9:0] a,
                         input logic [31:0] d, output int n);
    cpu_rd    = rd;
    cpu_wr    = wr;
    cpu_addr  = a;
    cpu_wdata = d;
    build(rd, wr, a, d);
    n = 0;
    while (q.size() > 0 && n < 64) begin
      cycle();
      n++;
    end
    if (q.size() != 0) begin
      chk("req_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  initial begin
    int          n;
    int          guard;
    logic [31:0] wd;
    bit          rd;
    bit          wr;
    logic [9:0]  a;

    total     = 0;
    bad       = 0;
    force_rdy = 1'b1;
    rst       = 1'b1;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    last_rdata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    for (int i = 0; i < 8; i++) begin
      mv[i] = 1'b0;
      mt[i] = '0;
    end

    @(posedge clk);
    #1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Cold read of 0x000: four refill words 0..3, then hit.
    racc.delete();
    run_req(1'b1, 1'b0, 10'h000, 32'h0, n);
    chk("cold_rd_cycles", 32'(n), 32'd6);
    chk("cold_rd_words", 32'(racc.size()), 32'd4);
    for (int k = 0; k < 4 && k < racc.size(); k++) chk("cold_rd_word_addr", 32'(racc[k]), 32'(k));

    // Immediate re-read in the same line: zero added cycles.
    racc.delete();
    run_req(1'b1, 1'b0, 10'h002, 32'h0, n);
    chk("hit_rd_cycles", 32'(n), 32'd1);
    chk("hit_rd_no_refill", 32'(racc.size()), 32'd0);

    // Write hit, then the written word reads back from the cache.
    run_req(1'b0, 1'b1, 10'h001, 32'hDEADBEEF, n);
    chk("wr_hit_cycles", 32'(n), 32'd3);
    racc.delete();
    run_req(1'b1, 1'b0, 10'h001, 32'h0, n);
    chk("wr_readback_cycles", 32'(n), 32'd1);
    chk("wr_readback_data", last_rdata, 32'hDEADBEEF);
    chk("wr_readback_no_refill", 32'(racc.size()), 32'd0);

    // Conflict eviction on index 0.
    run_req(1'b1, 1'b0, 10'h020, 32'h0, n);
    chk("evict_rd_cycles", 32'(n), 32'd6);
    run_req(1'b1, 1'b0, 10'h000, 32'h0, n);
    chk("evicted_rd_cycles", 32'(n), 32'd6);

    // Reset after the second refill word of a miss.
    racc.delete();
    cpu_rd   = 1'b1;
    cpu_addr = 10'h020;
    build(1'b1, 1'b0, 10'h020, 32'h0);
    guard = 0;
    while (racc.size() < 2 && guard < 32) begin
      cycle();
      guard++;
    end
    chk("abort_words_before_rst", 32'(racc.size()), 32'd2);
    rst = 1'b1;
    q.delete();
    cycle();
    rst    = 1'b0;
    cpu_rd = 1'b0;
    for (int i = 0; i < 8; i++) mv[i] = 1'b0;
    cycle();
    racc.delete();
    run_req(1'b1, 1'b0, 10'h000, 32'h0, n);
    chk("post_rst_rd_cycles", 32'(n), 32'd6);
    chk("post_rst_rd_words", 32'(racc.size()), 32'd4);
    run_req(1'b1, 1'b0, 10'h020, 32'h0, n);
    chk("post_rst_partial_line_cycles", 32'(n), 32'd6);

    // Combined read+write: write first, then a refill returns the new value.
    wd = $urandom;
    run_req(1'b1, 1'b1, 10'h005, wd, n);
    chk("rdwr_cycles", 32'(n), 32'd8);
    chk("rdwr_data", last_rdata, wd);

    // Randomized traffic with random memory latency.
    force_rdy = 1'b0;
    for (int t = 0; t < 300; t++) begin
      a  = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, 63));
      wd = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin rd = 1'b1; wr = 1'b0; end
        5, 6, 7:       begin rd = 1'b0; wr = 1'b1; end
        default:       begin rd = 1'b1; wr = 1'b1; end
      endcase
      run_req(rd, wr, a, wd, n);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
